mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LG_LINES, default 10, log2 of backing-store depth in 512-bit lines.
REQ-002 Parameter LATENCY, default 4, request-accept to response spacing in cycles; legal range 1..255.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mem_req_valid  input  1  request present; held high by initiator until it sees mem_rsp_valid.
REQ-006 mem_req_ack  output  1  one-cycle pulse: request accepted.
REQ-007 mem_req_addr  input  32  byte address; bits [5:0] ignored.
REQ-008 mem_req_store_data  input  512  store line data.
REQ-009 mem_req_opcode  input  4  4 = load line, 7 = store line, others illegal.
REQ-010 mem_rsp_valid  output  1  one-cycle completion pulse.
REQ-011 mem_rsp_load_data  output  512  load result; valid only with mem_rsp_valid.
REQ-012 init_done  output  1  high once backing store zeroed.
REQ-013 bad_opcode  output  1  sticky illegal-opcode flag.
REQ-014 load_count, store_count  output  64 each  completed loads / stores.

Function
REQ-015 Line index = mem_req_addr[LG_LINES+5:6]; bits above ignored (aliasing intended).
REQ-016 States: INIT, IDLE, BUSY, RESPOND, DRAIN.
REQ-017 INIT: write zero to line r_idx, r_idx increments each cycle; after line 2^LG_LINES-1 -> IDLE, init_done = 1; no request accepted in INIT.
REQ-018 IDLE with mem_req_valid = 1 in cycle A: latch index, opcode, store data; mem_req_ack = 1 in cycle A+1 only; load latency counter with LATENCY-1; -> BUSY.
REQ-019 BUSY: counter decrements each cycle; when counter = 0 perform array op (store: write latched data; load: synchronous read) and -> RESPOND.
REQ-020 mem_rsp_valid high exactly in cycle A+LATENCY+1, for one cycle, with mem_rsp_load_data = line contents (load) or all zeros (store or illegal).
REQ-021 Illegal opcode: no array write, zero data response, bad_opcode set until reset, neither count increments.
REQ-022 load_count / store_count increment in the mem_rsp_valid cycle; wrap modulo 2^64.
REQ-023 RESPOND -> DRAIN; DRAIN stays until mem_req_valid = 0 is sampled, then -> IDLE; a still-high valid after response is never re-accepted.
REQ-024 Back-to-back: valid low one cycle then high again -> new request accepted in the first IDLE cycle it is high.
REQ-025 Store followed by load of same line returns stored data (no stale read).
REQ-026 mem_req_ack and mem_rsp_valid never high in the same cycle when LATENCY >= 1.
REQ-027 Inputs other than mem_req_valid are sampled only in the accept cycle; later changes do not affect the operation in flight.

Reset
REQ-028 On reset: state = INIT, r_idx = 0, mem_req_ack = 0, mem_rsp_valid = 0, mem_rsp_load_data = 0, init_done = 0, bad_opcode = 0, counts = 0.
REQ-029 Reset during BUSY/RESPOND/DRAIN abandons the operation: no response issued, array re-zeroed by INIT.
REQ-030 Array contents not cleared by reset itself; zeroing comes only from INIT.

Verification
REQ-031 Reset, LG_LINES = 4: init_done rises after 16 INIT cycles; load 0x40 -> rsp data all zeros.
REQ-032 LATENCY = 4: store 0x1C0 data 0xA5..A5 accepted cycle A -> ack A+1, rsp A+5, store_count = 1; then load 0x1C0 -> data 0xA5..A5, load_count = 1.
REQ-033 Initiator holds valid high one cycle after rsp then drops, reasserts for next load -> exactly one ack per request, no duplicate rsp.
REQ-034 Opcode 3 at 0x80 -> rsp zeros, bad_opcode = 1, counts unchanged, line 0x80 unchanged on later load.
REQ-035 LG_LINES = 4: store to 0x400 then load 0x0 -> returns stored data (alias).
REQ-036 Reset asserted in BUSY -> no mem_rsp_valid, init_done = 0 until INIT completes, prior stores read back zero.

Source files
------------

// File: rtl/mem_responder.sv
// Purpose : single-port line-granular memory model that answers one load/store
//           request at a time from an internal 2^LG_LINES x 512-bit array.
// Latency : response pulse LATENCY+1 cycles after the accept cycle (ack at +1).
// Backpr. : no queueing; a request waits on mem_req_valid until IDLE, and a
//           valid still high after the response is ignored until it drops.
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   mem_req_valid       request present, held until the response is seen
//   mem_req_ack         one-cycle accept pulse
//   mem_req_addr        byte address; line index = addr[LG_LINES+5:6]
//   mem_req_store_data  line data for stores
//   mem_req_opcode      4 = load line, 7 = store line, anything else illegal
//   mem_rsp_valid       one-cycle completion pulse
//   mem_rsp_load_data   load data (zero for stores and illegal opcodes)
//   init_done           high once the array has been zeroed after reset
//   bad_opcode          sticky illegal-opcode flag, cleared only by reset
//   load_count          completed loads (wraps at 2^64)
//   store_count         completed stores (wraps at 2^64)

module mem_responder #(
  parameter int LG_LINES = 10,
  parameter int LATENCY  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_req_valid,
  output logic         mem_req_ack,
  input  logic [31:0]  mem_req_addr,
  input  logic [511:0] mem_req_store_data,
  input  logic [3:0]   mem_req_opcode,
  output logic         mem_rsp_valid,
  output logic [511:0] mem_rsp_load_data,
  output logic         init_done,
  output logic         bad_opcode,
  output logic [63:0]  load_count,
  output logic [63:0]  store_count
);

  localparam int                  LINES     = 1 << LG_LINES;
  localparam logic [3:0]          OP_LOAD   = 4'd4;
  localparam logic [3:0]          OP_STORE  = 4'd7;
  localparam logic [7:0]          LAT_START = 8'(LATENCY - 1);
  localparam logic [LG_LINES-1:0] LAST_IDX  = '1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_BUSY,
    S_RESPOND,
    S_DRAIN
  } state_t;

  state_t              state;
  logic [LG_LINES-1:0] r_idx;      // INIT sweep pointer
  logic [LG_LINES-1:0] req_idx;    // latched request line
  logic [3:0]          req_op;
  logic [511:0]        req_data;
  logic [7:0]          lat_cnt;

  logic [511:0]        mem [LINES];

  logic                mem_we;
  logic [LG_LINES-1:0] mem_waddr;
  logic [511:0]        mem_wdata;
  logic                op_fire;

  // Upper address bits alias onto the same lines on purpose; the byte offset
  // inside a line is meaningless for whole-line transfers.
  logic [LG_LINES-1:0] req_line;
  logic                unused_addr_bits;
  assign req_line         = mem_req_addr[LG_LINES+5:6];
  assign unused_addr_bits = ^{mem_req_addr[31:LG_LINES+6], mem_req_addr[5:0]};

  // The array operation happens on the last BUSY cycle, so the registered
  // response lands exactly LATENCY+1 cycles after the accept cycle.
  assign op_fire = (state == S_BUSY) && (lat_cnt == 8'd0);

  // Single write port shared by the INIT sweep and stores. Writes are blocked
  // while reset is asserted so an abandoned store never reaches the array.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = r_idx;
    mem_wdata = '0;
    if (!reset) begin
      if (state == S_INIT) begin
        mem_we = 1'b1;
      end else if (op_fire && (req_op == OP_STORE)) begin
        mem_we    = 1'b1;
        mem_waddr = req_idx;
        mem_wdata = req_data;
      end
    end
  end

  // Array storage has no reset; contents are only cleared by the INIT sweep.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_INIT;
      r_idx             <= '0;
      req_idx           <= '0;
      req_op            <= '0;
      req_data          <= '0;
      lat_cnt           <= '0;
      mem_req_ack       <= 1'b0;
      mem_rsp_valid     <= 1'b0;
      mem_rsp_load_data <= '0;
      init_done         <= 1'b0;
      bad_opcode        <= 1'b0;
      load_count        <= '0;
      store_count       <= '0;
    end else begin
      mem_req_ack   <= 1'b0;
      mem_rsp_valid <= 1'b0;

      case (state)
        S_INIT: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            state     <= S_IDLE;
            init_done <= 1'b1;
          end
        end

        S_IDLE: begin
          // All request fields are captured here and never looked at again.
          if (mem_req_valid) begin
            req_idx     <= req_line;
            req_op      <= mem_req_opcode;
            req_data    <= mem_req_store_data;
            lat_cnt     <= LAT_START;
            mem_req_ack <= 1'b1;
            state       <= S_BUSY;
          end
        end

        S_BUSY: begin
          if (lat_cnt == 8'd0) begin
            mem_rsp_valid     <= 1'b1;
            mem_rsp_load_data <= '0;
            state             <= S_RESPOND;
            case (req_op)
              OP_LOAD: begin
                mem_rsp_load_data <= mem[req_idx];
                load_count        <= load_count + 64'd1;
              end
              OP_STORE: begin
                store_count <= store_count + 64'd1;
              end
              default: begin
                bad_opcode <= 1'b1;
              end
            endcase
          end else begin
            lat_cnt <= lat_cnt - 8'd1;
          end
        end

        S_RESPOND: begin
          state <= S_DRAIN;
        end

        S_DRAIN: begin
          // The initiator may still be holding valid from the finished
          // request; wait for it to drop so that request is not re-accepted.
          if (!mem_req_valid) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule
